// File: rtl/sfp_pkg.sv
// Shared constants, FSM encoding and the frame checksum helper for the sensor frame packer.
package sfp_pkg;

  localparam int unsigned FRAME_LEN = 10;
  localparam int unsigned IDX_SEQ   = 2;
  localparam int unsigned IDX_CSUM  = 9;

  localparam logic [7:0] DEF_HDR0 = 8'hAA;
  localparam logic [7:0] DEF_HDR1 = 8'h55;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Modulo-256 sum of frame bytes seq .. z[7:0].
  function automatic logic [7:0] frame_csum(input logic [7:0]  s,
                                            input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic [15:0] z);
    return s + x[15:8] + x[7:0] + y[15:8] + y[7:0] + z[15:8] + z[7:0];
  endfunction

endpackage

// File: rtl/sfp_decimator.sv
// Counts qualifying samples modulo DECIM and flags the one that should start a frame.
module sfp_decimator #(
  parameter int unsigned DECIM = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic sample_valid,
  output logic trigger
);

  logic [7:0] cnt_q;
  logic       qualify;
  logic       at_last;

  assign qualify = enable && sample_valid;
  assign at_last = (cnt_q == 8'(DECIM - 1));
  assign trigger = qualify && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (qualify) begin
      cnt_q <= at_last ? '0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/sensor_frame_packer.sv
// Snapshots x/y/z on a decimated trigger and streams a 10-byte framed packet
// (header, seq, axes, checksum) over a byte-wide valid/ready interface.
module sensor_frame_packer
  import sfp_pkg::*;
#(
  parameter logic [7:0]  HDR0  = DEF_HDR0,
  parameter logic [7:0]  HDR1  = DEF_HDR1,
  parameter int unsigned DECIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] x_axis,
  input  logic [15:0] y_axis,
  input  logic [15:0] z_axis,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  seq,
  output logic [7:0]  drop_cnt
);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] x_q, y_q, z_q;
  logic [7:0]  snap_seq_q, csum_q, seq_q, drop_q;
  logic [7:0]  seq_next;
  logic        trigger, xfer, last, capture, drop_inc;

  sfp_decimator #(.DECIM(DECIM)) u_decim (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .trigger      (trigger)
  );

  assign xfer     = (state_q == SEND) && tx_ready;
  assign last     = xfer && (idx_q == 4'(IDX_CSUM));
  // A back-to-back frame must carry the already-incremented sequence number.
  assign seq_next = last ? seq_q + 8'd1 : seq_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    capture  = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          capture = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (last) begin
            idx_d = '0;
            if (trigger) capture = 1'b1;
            else         state_d = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        if (trigger && !last) drop_inc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_data = '0;
    if (state_q == SEND) begin
      case (idx_q)
        4'd0:            tx_data = HDR0;
        4'd1:            tx_data = HDR1;
        4'(IDX_SEQ):     tx_data = snap_seq_q;
        4'd3:            tx_data = x_q[15:8];
        4'd4:            tx_data = x_q[7:0];
        4'd5:            tx_data = y_q[15:8];
        4'd6:            tx_data = y_q[7:0];
        4'd7:            tx_data = z_q[15:8];
        4'd8:            tx_data = z_q[7:0];
        4'(IDX_CSUM):    tx_data = csum_q;
        default:         tx_data = '0;
      endcase
    end
  end

  assign tx_valid = (state_q == SEND);
  assign busy     = (state_q == SEND);
  assign seq      = seq_q;
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      seq_q      <= '0;
      drop_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      snap_seq_q <= '0;
      csum_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_next;
      if (drop_inc && drop_q != '1) drop_q <= drop_q + 8'd1;
      if (capture) begin
        x_q        <= x_axis;
        y_q        <= y_axis;
        z_q        <= z_axis;
        snap_seq_q <= seq_next;
        csum_q     <= frame_csum(seq_next, x_axis, y_axis, z_axis);
      end
    end
  end

endmodule

// File: tb/tb_sensor_frame_packer.sv
// Scoreboard bench for sensor_frame_packer: a frame-level reference model queues expected
// bytes per instance (DECIM=1 and DECIM=4) and monitors pop them on each DUT transfer.
module tb_sensor_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] x_axis = '0, y_axis = '0, z_axis = '0;
  logic        tx_ready = 1'b1;

  logic [7:0]  txd   [2];
  logic        txv   [2];
  logic        bsy   [2];
  logic [7:0]  sq    [2];
  logic [7:0]  drp   [2];

  int passed = 0;
  int total  = 0;

  int          decim  [2] = '{1, 4};
  int          m_cnt  [2];
  int          m_rem  [2];
  int          m_seq  [2];
  int          m_drop [2];
  bit          m_busy [2];
  logic [7:0]  exp_q  [2][$];

  always #5 clk = ~clk;

  sensor_frame_packer #(.HDR0(8'hAA), .HDR1(8'h55), .DECIM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .x_axis(x_axis), .y_axis(y_axis), .z_axis(z_axis),
    .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(tx_ready),
    .busy(bsy[0]), .seq(sq[0]), .drop_cnt(drp[0])
  );

  sensor_frame_packer #(.HDR0(8'hAA), .HDR1(8'h55), .DECIM(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .x_axis(x_axis), .y_axis(y_axis), .z_axis(z_axis),
    .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(tx_ready),
    .busy(bsy[1]), .seq(sq[1]), .drop_cnt(drp[1])
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: decides per clock edge what the packer should do at frame granularity.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_rem[k] = 0; m_seq[k] = 0; m_drop[k] = 0; m_busy[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          m_cnt[k] = 0; m_rem[k] = 0; m_seq[k] = 0; m_drop[k] = 0; m_busy[k] = 0;
          exp_q[k].delete();
        end else begin
          bit xfer, last, qual, trig;
          check($sformatf("busy%0d", k),     int'(bsy[k]), int'(m_busy[k]));
          check($sformatf("tx_valid%0d", k), int'(txv[k]), int'(m_busy[k]));
          check($sformatf("seq%0d", k),      int'(sq[k]),  m_seq[k]);
          check($sformatf("drop_cnt%0d", k), int'(drp[k]), m_drop[k]);
          xfer = m_busy[k] && tx_ready;
          last = xfer && (m_rem[k] == 1);
          qual = enable && sample_valid;
          trig = qual && (m_cnt[k] == decim[k] - 1);
          if (qual) m_cnt[k] = (m_cnt[k] + 1) % decim[k];
          if (xfer) m_rem[k]--;
          if (last) begin
            m_seq[k]  = (m_seq[k] + 1) % 256;
            m_busy[k] = 0;
          end
          if (trig) begin
            if (!m_busy[k]) begin
              int sum;
              logic [7:0] b [7];
              b[0] = 8'(m_seq[k]);
              b[1] = x_axis[15:8]; b[2] = x_axis[7:0];
              b[3] = y_axis[15:8]; b[4] = y_axis[7:0];
              b[5] = z_axis[15:8]; b[6] = z_axis[7:0];
              sum = 0;
              exp_q[k].push_back(8'hAA);
              exp_q[k].push_back(8'h55);
              for (int i = 0; i < 7; i++) begin
                exp_q[k].push_back(b[i]);
                sum += int'(b[i]);
              end
              exp_q[k].push_back(8'(sum % 256));
              m_busy[k] = 1;
              m_rem[k]  = 10;
            end else if (m_drop[k] < 255) begin
              m_drop[k]++;
            end
          end
        end
      end
    end
  end

  // Monitor: every presented byte must match the head of the expected stream.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) begin
          if (txv[k]) begin
            if (exp_q[k].size() == 0) begin
              check($sformatf("unexpected_byte%0d", k), int'(txv[k]), 0);
            end else begin
              check($sformatf("tx_data%0d", k), int'(txd[k]), int'(exp_q[k][0]));
              if (tx_ready) void'(exp_q[k].pop_front());
            end
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    x_axis = x; y_axis = y; z_axis = z;
    sample_valid = 1'b1;
    cyc(1);
    sample_valid = 1'b0;
    x_axis = 16'($urandom); y_axis = 16'($urandom); z_axis = 16'($urandom);
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Basic frame, ready held high
    tx_ready = 1'b1;
    pulse(16'h1234, 16'h5678, 16'h9ABC);
    cyc(14);

    // Same sample with ready toggling 1-0-0-1
    pulse(16'h1234, 16'h5678, 16'h9ABC);
    for (int i = 0; i < 44; i++) begin
      tx_ready = pat[i % 4];
      cyc(1);
    end
    tx_ready = 1'b1;
    cyc(12);

    // Triggers while stalled, then drop counter saturation
    tx_ready = 1'b0;
    pulse(16'h0102, 16'h0304, 16'h0506);
    repeat (3) begin
      cyc(4);
      pulse(16'($urandom), 16'($urandom), 16'($urandom));
    end
    cyc(4);
    sample_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x_axis = 16'($urandom);
      cyc(1);
    end
    sample_valid = 1'b0;
    tx_ready = 1'b1;
    cyc(15);

    // Trigger coincident with the last-byte transfer
    pulse(16'h1234, 16'h5678, 16'h9ABC);
    cyc(9);
    pulse(16'h0000, 16'h0000, 16'h0000);
    cyc(14);

    // Reset in the middle of a frame
    pulse(16'hCAFE, 16'hBEEF, 16'h0F0F);
    cyc(5);
    rst_n = 1'b0;
    #1;
    check("rst_tx_valid", int'(txv[0]), 0);
    check("rst_tx_data",  int'(txd[0]), 0);
    check("rst_busy",     int'(bsy[0]), 0);
    check("rst_seq",      int'(sq[0]),  0);
    check("rst_drop",     int'(drp[0]), 0);
    check("rst_drop4",    int'(drp[1]), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    pulse(16'h1111, 16'h2222, 16'h3333);
    cyc(14);

    // Decimation with interleaved disabled pulses, from a clean counter
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    for (int p = 0; p < 8; p++) begin
      enable = 1'b0;
      pulse(16'($urandom), 16'($urandom), 16'($urandom));
      cyc(10);
      enable = 1'b1;
      pulse(16'($urandom), 16'($urandom), 16'($urandom));
      cyc(19);
    end

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      sample_valid = ($urandom_range(0, 7) == 0);
      enable       = ($urandom_range(0, 9) != 0);
      tx_ready     = ($urandom_range(0, 3) != 0);
      x_axis = 16'($urandom); y_axis = 16'($urandom); z_axis = 16'($urandom);
      cyc(1);
    end
    sample_valid = 1'b0;
    enable = 1'b1;
    tx_ready = 1'b1;
    cyc(15);

    check("pending_bytes0", exp_q[0].size(), 0);
    check("pending_bytes1", exp_q[1].size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
